// File: rtl/alu_seq.sv
// Multi-cycle ALU: binary operations complete in one EXEC cycle, decimal ADD/SUB
// walk the operands one nibble per cycle in ADJ with a registered digit carry.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       operation,
  input  logic             decimal,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out,
  output logic             negative_out,
  output logic             done,
  output logic [1:0]       state_dbg
);
  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start while ready=0 has no effect. done pulses for one cycle with new outputs.

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_EOR = 4'd4, OP_ASL = 4'd5, OP_LSR = 4'd6, OP_ROL = 4'd7,
                         OP_ROR = 4'd8, OP_INC = 4'd9, OP_DEC = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, ADJ} state_t;
  state_t state, next_state;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q, dc_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] b_eff, bin_res, bcd_word;
  logic [WIDTH:0]   sum;
  logic             sum_v, bin_c, bin_v, nib_c, last;
  logic [3:0]       na, nb, nib;
  logic [4:0]       s5;
  logic [5:0]       d6;

  assign ready     = (state == IDLE);
  assign state_dbg = state;
  assign last      = (cnt_q == CW'(NIB - 1));

  // Shared binary adder; its signed overflow also serves the decimal path.
  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_q};
    sum_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    bin_res = a_q;
    bin_c   = 1'b0;
    bin_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin bin_res = sum[WIDTH-1:0]; bin_c = sum[WIDTH]; bin_v = sum_v; end
      OP_AND: bin_res = a_q & b_q;
      OP_OR:  bin_res = a_q | b_q;
      OP_EOR: bin_res = a_q ^ b_q;
      OP_ASL: begin bin_res = {a_q[WIDTH-2:0], 1'b0}; bin_c = a_q[WIDTH-1]; end
      OP_LSR: begin bin_res = {1'b0, a_q[WIDTH-1:1]}; bin_c = a_q[0]; end
      OP_ROL: begin bin_res = {a_q[WIDTH-2:0], c_q};  bin_c = a_q[WIDTH-1]; end
      OP_ROR: begin bin_res = {c_q, a_q[WIDTH-1:1]};  bin_c = a_q[0]; end
      OP_INC: bin_res = a_q + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: bin_res = a_q - {{(WIDTH-1){1'b0}}, 1'b1};
      default: bin_res = a_q;
    endcase
  end

  // One BCD digit per cycle; dc_q holds carry (ADD) or not-borrow (SUB).
  always_comb begin
    na    = a_q[{cnt_q, 2'b00} +: 4];
    nb    = b_q[{cnt_q, 2'b00} +: 4];
    s5    = {1'b0, na} + {1'b0, nb} + {4'b0000, dc_q};
    d6    = {2'b00, na} - {2'b00, nb} - {5'b00000, ~dc_q};
    nib   = s5[3:0];
    nib_c = 1'b0;
    if (op_q == OP_SUB) begin
      nib   = d6[5] ? (d6[3:0] - 4'd6) : d6[3:0];
      nib_c = ~d6[5];
    end else if (s5 > 5'd9) begin
      nib   = s5[3:0] + 4'd6;
      nib_c = 1'b1;
    end
    bcd_word = res_q;
    bcd_word[{cnt_q, 2'b00} +: 4] = nib;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start)
              next_state = (decimal && (operation == OP_ADD || operation == OP_SUB)) ? ADJ : EXEC;
      EXEC: next_state = IDLE;
      ADJ:  if (last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
      negative_out <= 1'b0;
      done         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      dc_q         <= 1'b0;
      cnt_q        <= '0;
      res_q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= operation;
          a_q   <= input_a;
          b_q   <= input_b;
          c_q   <= carry_in;
          dc_q  <= carry_in;
          cnt_q <= '0;
          res_q <= '0;
        end
        EXEC: begin
          alu_out      <= bin_res;
          carry_out    <= bin_c;
          overflow_out <= bin_v;
          zero_out     <= (bin_res == '0);
          negative_out <= bin_res[WIDTH-1];
          done         <= 1'b1;
        end
        ADJ: begin
          res_q <= bcd_word;
          dc_q  <= nib_c;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            alu_out      <= bcd_word;
            carry_out    <= nib_c;
            overflow_out <= sum_v;
            zero_out     <= (bcd_word == '0);
            negative_out <= bcd_word[WIDTH-1];
            done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16; expected results are queued
// at issue time and popped by per-instance monitors on each done pulse.
module tb_alu_seq;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, EOR = 4'd4,
                         ASL = 4'd5, LSR = 4'd6, ROL = 4'd7, ROR = 4'd8, INC = 4'd9,
                         DEC = 4'd10, BAD = 4'd11;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  flg;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start8, start16, ready8, ready16, dec8, dec16, c8, c16;
  logic [3:0] op8, op16;
  logic [7:0] a8, b8, out8;
  logic [15:0] a16, b16, out16;
  logic co8, vo8, zo8, no8, done8, co16, vo16, zo16, no16, done16;
  logic [1:0] st8, st16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ready(ready8), .operation(op8),
    .decimal(dec8), .carry_in(c8), .input_a(a8), .input_b(b8), .alu_out(out8),
    .carry_out(co8), .overflow_out(vo8), .zero_out(zo8), .negative_out(no8),
    .done(done8), .state_dbg(st8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .ready(ready16), .operation(op16),
    .decimal(dec16), .carry_in(c16), .input_a(a16), .input_b(b16), .alu_out(out16),
    .carry_out(co16), .overflow_out(vo16), .zero_out(zo16), .negative_out(no16),
    .done(done16), .state_dbg(st16)
  );

  exp_t q8[$];
  exp_t q16[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_d = 1'b1;
  logic [19:0] prev8, prev16;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("out8", {24'd0, out8}, {24'd0, e.out[7:0]});
        check("flags8_cvzn", {28'd0, co8, vo8, zo8, no8}, {28'd0, e.flg});
        check("latency8", cyc, e.due);
      end
    end else if (!rst_d) begin
      check("hold8", {12'd0, out8, co8, vo8, zo8, no8, 4'd0}, {12'd0, prev8});
    end
    prev8 = {out8, co8, vo8, zo8, no8, 4'd0};
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) check("done16_unexpected", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("out16", {16'd0, out16}, {16'd0, e.out});
        check("flags16_cvzn", {28'd0, co16, vo16, zo16, no16}, {28'd0, e.flg});
        check("latency16", cyc, e.due);
      end
    end else if (!rst_d) begin
      check("hold16", {12'd0, out16, co16, vo16, zo16, no16}, {12'd0, prev16});
    end
    prev16 = {out16, co16, vo16, zo16, no16};
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input bit wide, input logic [3:0] op, input logic dec, input logic c,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic [3:0] ef, input int lat, input bit push);
    int guard = 0;
    while (((wide ? ready16 : ready8) !== 1'b1) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check(wide ? "ready16_timeout" : "ready8_timeout", 32'd0, 32'd1);
    if (wide) begin
      start16 = 1'b1; op16 = op; dec16 = dec; c16 = c; a16 = a; b16 = b;
    end else begin
      start8 = 1'b1; op8 = op; dec8 = dec; c8 = c; a8 = a[7:0]; b8 = b[7:0];
    end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    if (push) begin
      exp_t e;
      e.out = eo;
      e.flg = ef;
      e.due = 32'(cyc + lat);
      if (wide) q16.push_back(e);
      else      q8.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start8 = 1'b0; op8 = '0; dec8 = 1'b0; c8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = '0; dec16 = 1'b0; c16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out8", {24'd0, out8}, 32'd0);
    check("rst_flags8", {27'd0, co8, vo8, zo8, no8, done8}, 32'd0);
    check("rst_ready8", {31'd0, ready8}, 32'd1);
    check("rst_out16", {16'd0, out16}, 32'd0);
    check("rst_ready16", {31'd0, ready16}, 32'd1);
    @(posedge clk); #1;

    // flags are {C,V,Z,N}
    issue(0, ADD,  0, 1, 16'h06, 16'h05, 16'h0C, 4'b0000, 1, 1);
    issue(0, ADD,  0, 0, 16'h7F, 16'h01, 16'h80, 4'b0101, 1, 1);
    issue(0, ROR,  0, 1, 16'h01, 16'h00, 16'h80, 4'b1001, 1, 1);

    // decimal ADD with a competing start held while busy
    issue(0, ADD,  1, 1, 16'h58, 16'h46, 16'h05, 4'b1100, 2, 1);
    start8 = 1'b1; op8 = AND_; dec8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    check("ready8_busy_a", {31'd0, ready8}, 32'd0);
    @(posedge clk); #1;
    check("ready8_busy_b", {31'd0, ready8}, 32'd0);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("ready8_after_done", {31'd0, ready8}, 32'd1);

    issue(0, SUB,  1, 1, 16'h46, 16'h12, 16'h34, 4'b1000, 2, 1);
    issue(0, SUB,  1, 1, 16'h12, 16'h21, 16'h91, 4'b0001, 2, 1);
    issue(0, AND_, 0, 1, 16'hC3, 16'h01, 16'h01, 4'b0000, 1, 1);
    issue(0, EOR,  0, 0, 16'hFF, 16'hFF, 16'h00, 4'b0010, 1, 1);
    issue(0, BAD,  0, 1, 16'h85, 16'h33, 16'h85, 4'b0001, 1, 1);
    issue(0, SUB,  0, 1, 16'h10, 16'h20, 16'hF0, 4'b0001, 1, 1);
    issue(0, DEC,  0, 1, 16'h00, 16'h00, 16'hFF, 4'b0001, 1, 1);
    issue(0, INC,  0, 1, 16'hFF, 16'h00, 16'h00, 4'b0010, 1, 1);
    issue(0, LSR,  0, 1, 16'h81, 16'h00, 16'h40, 4'b1000, 1, 1);
    issue(0, ASL,  0, 1, 16'h81, 16'h00, 16'h02, 4'b1000, 1, 1);
    issue(0, ROL,  0, 1, 16'h80, 16'h00, 16'h01, 4'b1000, 1, 1);
    issue(0, OR_,  0, 0, 16'h0F, 16'hF0, 16'hFF, 4'b0001, 1, 1);
    issue(0, AND_, 1, 0, 16'h0F, 16'h3C, 16'h0C, 4'b0000, 1, 1);
    issue(0, ADD,  1, 0, 16'h99, 16'h01, 16'h00, 4'b1010, 2, 1);
    issue(0, ADD,  1, 0, 16'h0A, 16'h00, 16'h10, 4'b0000, 2, 1);
    issue(0, ADD,  0, 0, 16'hFF, 16'h01, 16'h00, 4'b1010, 1, 1);
    repeat (4) @(posedge clk); #1;

    issue(1, ADD, 1, 0, 16'h1234, 16'h5678, 16'h6912, 4'b0000, 4, 1);
    // abort a decimal ADD with reset sampled on its second ADJ edge
    issue(1, ADD, 1, 0, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 4, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out16", {16'd0, out16}, 32'd0);
    check("abort_flags16", {27'd0, co16, vo16, zo16, no16, done16}, 32'd0);
    check("abort_ready16", {31'd0, ready16}, 32'd1);
    repeat (6) @(posedge clk); #1;
    issue(1, ADD, 0, 0, 16'h1234, 16'h0001, 16'h1235, 4'b0000, 1, 1);

    repeat (10) @(posedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q16_drained", q16.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
